// File: rtl/stereo_frame_streamer.sv
// Streams one interleaved-RGB frame per side from two lock-stepped frame memories,
// then presents the captured left/right keypoint pair with a single-cycle strobe.
module stereo_frame_streamer #(
  parameter int N       = 450,
  parameter int M       = 450,
  parameter int CH      = 3,
  parameter int ADDR_W  = 20,
  parameter int MEM_LAT = 2,
  parameter int KP_GAP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       left_kp_in,
  input  logic [31:0]       right_kp_in,
  input  logic              hold,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        left_mem_data,
  input  logic [7:0]        right_mem_data,
  output logic              left_data_valid,
  output logic [7:0]        left_data,
  output logic              right_data_valid,
  output logic [7:0]        right_data,
  output logic              keypoint_valid,
  output logic [31:0]       left_keypoint,
  output logic [31:0]       right_keypoint,
  output logic              busy,
  output logic              done,
  output logic              kp_error
);

  localparam int                FRAME     = CH * N * M;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);
  localparam logic [31:0]       PIXELS    = 32'(N * M);
  localparam int                GAP_W     = $clog2(KP_GAP + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(KP_GAP - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, GAP, KEY} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  addr_cnt;
  logic [MEM_LAT-1:0] vld_pipe;
  logic [GAP_W-1:0]   gap_cnt;
  logic               kp_ok;
  logic               accept;

  assign kp_ok  = (left_kp_in < PIXELS) && (right_kp_in < PIXELS);
  assign accept = (state == IDLE) && start && kp_ok;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (!hold && addr_cnt == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:   if (vld_pipe == '0) state_nxt = GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = KEY;
      KEY:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en      = (state == ISSUE) && !hold;
    keypoint_valid = (state == KEY);
    done           = (state == KEY);
    busy           = (state != IDLE);
  end

  // The counter wraps to 0 on the final read so mem_addr never leaves 0..FRAME-1.
  assign mem_addr = addr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt       <= '0;
      gap_cnt        <= '0;
      left_keypoint  <= '0;
      right_keypoint <= '0;
      kp_error       <= 1'b0;
    end else begin
      kp_error <= (state == IDLE) && start && !kp_ok;
      if (accept) begin
        addr_cnt       <= '0;
        left_keypoint  <= left_kp_in;
        right_keypoint <= right_kp_in;
      end else if (mem_rd_en) begin
        addr_cnt <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + 1'b1;
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  // Valid pipeline tracks reads in flight; its tail marks the cycle the memories present data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe         <= '0;
      left_data_valid  <= 1'b0;
      right_data_valid <= 1'b0;
      left_data        <= '0;
      right_data       <= '0;
    end else begin
      vld_pipe[0] <= mem_rd_en;
      for (int i = 1; i < MEM_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      left_data_valid  <= vld_pipe[MEM_LAT-1];
      right_data_valid <= vld_pipe[MEM_LAT-1];
      left_data        <= vld_pipe[MEM_LAT-1] ? left_mem_data  : 8'h00;
      right_data       <= vld_pipe[MEM_LAT-1] ? right_mem_data : 8'h00;
    end
  end

endmodule

// File: tb/tb_stereo_frame_streamer.sv
// Directed bench for stereo_frame_streamer with a 2-cycle-latency memory model
// (left = addr, right = addr + 0x80) on a 2x2x3 frame.
module tb_stereo_frame_streamer;

  localparam int ADDR_W = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              hold = 1'b0;
  logic [31:0]       left_kp_in = '0;
  logic [31:0]       right_kp_in = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        left_mem_data, right_mem_data;
  logic              left_data_valid, right_data_valid;
  logic [7:0]        left_data, right_data;
  logic              keypoint_valid, busy, done, kp_error;
  logic [31:0]       left_keypoint, right_keypoint;

  stereo_frame_streamer #(
    .N(2), .M(2), .CH(3), .ADDR_W(ADDR_W), .MEM_LAT(2), .KP_GAP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .left_kp_in(left_kp_in), .right_kp_in(right_kp_in), .hold(hold),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .left_mem_data(left_mem_data), .right_mem_data(right_mem_data),
    .left_data_valid(left_data_valid), .left_data(left_data),
    .right_data_valid(right_data_valid), .right_data(right_data),
    .keypoint_valid(keypoint_valid), .left_keypoint(left_keypoint),
    .right_keypoint(right_keypoint), .busy(busy), .done(done), .kp_error(kp_error)
  );

  always #5 clk = ~clk;

  // Memory model: read in cycle c presents data in cycle c+2; idle reads show 0xEE.
  logic [7:0] a1 = 8'hEE, a2 = 8'hEE;
  always @(posedge clk) begin
    a1 <= mem_rd_en ? mem_addr[7:0] : 8'hEE;
    a2 <= a1;
  end
  assign left_mem_data  = a2;
  assign right_mem_data = a2 + 8'h80;

  typedef struct { int cyc; logic [7:0] l; logic [7:0] r; } beat_t;

  int          cyc = 0;
  beat_t       beats[$];
  int          rd_cyc[$];
  logic [31:0] rd_addr[$];
  int          kp_cyc[$];
  logic [31:0] kp_l[$], kp_r[$];
  int          err_pulses = 0;
  int          viol = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Log interface activity mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (left_data_valid) beats.push_back('{cyc, left_data, right_data});
    if (mem_rd_en) begin
      rd_cyc.push_back(cyc);
      rd_addr.push_back(32'(mem_addr));
    end
    if (keypoint_valid) begin
      kp_cyc.push_back(cyc);
      kp_l.push_back(left_keypoint);
      kp_r.push_back(right_keypoint);
    end
    if (kp_error) err_pulses++;
    if (left_data_valid !== right_data_valid) viol++;
    if (!left_data_valid && left_data !== 8'h00) viol++;
    if (!right_data_valid && right_data !== 8'h00) viol++;
    if (done !== keypoint_valid) viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    beats.delete(); rd_cyc.delete(); rd_addr.delete();
    kp_cyc.delete(); kp_l.delete(); kp_r.delete();
    err_pulses = 0;
  endtask

  task automatic pulse_start(input logic [31:0] lk, input logic [31:0] rk);
    left_kp_in = lk; right_kp_in = rk; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Checks one 12-beat frame starting at log index b0: addresses and both streams in order.
  task automatic check_frame(input string tag, input int b0);
    for (int i = 0; i < 12; i++) begin
      if (b0 + i < rd_addr.size()) check({tag, "_addr"}, rd_addr[b0+i], 32'(i));
      if (b0 + i < beats.size()) begin
        check({tag, "_left"},  32'(beats[b0+i].l), 32'(i));
        check({tag, "_right"}, 32'(beats[b0+i].r), 32'(8'h80 + i));
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_strobes"}, 32'({mem_rd_en, left_data_valid, right_data_valid,
                                  keypoint_valid, busy, done, kp_error}), 32'h0);
    check({tag, "_data"}, 32'({left_data, right_data}), 32'h0);
    check({tag, "_addr"}, 32'(mem_addr), 32'h0);
    check({tag, "_kps"}, left_keypoint | right_keypoint, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int sc;

    // Reset state
    #1;
    check_idle_outputs("reset");
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Basic frame, keypoints 1/2
    clear_log();
    check("basic_busy_pre", 32'(busy), 32'h0);
    pulse_start(32'd1, 32'd2);
    check("basic_busy_post", 32'(busy), 32'h1);
    tick(35);
    check("basic_rd_count", rd_cyc.size(), 12);
    check("basic_rd_span", rd_cyc[11] - rd_cyc[0], 11);
    check("basic_beat_count", beats.size(), 12);
    check("basic_first_lat", beats[0].cyc - rd_cyc[0], 3);
    check("basic_beat_span", beats[11].cyc - beats[0].cyc, 11);
    check_frame("basic", 0);
    check("basic_kp_count", kp_cyc.size(), 1);
    check("basic_kp_gap", kp_cyc[0] - beats[11].cyc, 5);
    check("basic_kp_left", kp_l[0], 32'd1);
    check("basic_kp_right", kp_r[0], 32'd2);
    check("basic_busy_end", 32'(busy), 32'h0);

    // Hold for 3 cycles after 4 reads
    clear_log();
    pulse_start(32'd0, 32'd0);
    tick(4);
    hold = 1'b1;
    tick(3);
    hold = 1'b0;
    tick(35);
    check("hold_rd_count", rd_cyc.size(), 12);
    check("hold_rd_gap", rd_cyc[4] - rd_cyc[3], 4);
    check("hold_rd_span", rd_cyc[11] - rd_cyc[0], 14);
    check("hold_beat_count", beats.size(), 12);
    check("hold_beat_gap", beats[4].cyc - beats[3].cyc, 4);
    check("hold_beat_span", beats[11].cyc - beats[0].cyc, 14);
    check_frame("hold", 0);
    check("hold_kp_count", kp_cyc.size(), 1);

    // Keypoint reject, then retry
    clear_log();
    pulse_start(32'd4, 32'd0);
    check("rej_err_pulse", 32'(kp_error), 32'h1);
    check("rej_busy", 32'(busy), 32'h0);
    tick(1);
    check("rej_err_clear", 32'(kp_error), 32'h0);
    tick(4);
    check("rej_err_count", err_pulses, 1);
    check("rej_rd_count", rd_cyc.size(), 0);
    clear_log();
    pulse_start(32'd3, 32'd0);
    tick(35);
    check("retry_beat_count", beats.size(), 12);
    check_frame("retry", 0);
    check("retry_kp_left", kp_l[0], 32'd3);
    check("retry_kp_right", kp_r[0], 32'd0);
    check("retry_err_count", err_pulses, 0);

    // Start pulses while busy are ignored; start right after done is accepted
    clear_log();
    pulse_start(32'd2, 32'd1);
    tick(2);
    start = 1'b1;
    tick(3);
    start = 1'b0;
    tick(11);
    start = 1'b1;
    tick(2);
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 60) begin tick(1); k++; end
    check("busy_done_seen", 32'(done), 32'h1);
    tick(1);
    pulse_start(32'd0, 32'd3);
    tick(35);
    check("busy_rd_count", rd_cyc.size(), 24);
    check("busy_beat_count", beats.size(), 24);
    check("busy_kp_count", kp_cyc.size(), 2);
    check("busy_f1_kp_gap", kp_cyc[0] - beats[11].cyc, 5);
    check("busy_f2_restart", rd_cyc[12] - kp_cyc[0], 2);
    check_frame("busy_f1", 0);
    check_frame("busy_f2", 12);
    check("busy_kp2_left", kp_l[1], 32'd0);
    check("busy_kp2_right", kp_r[1], 32'd3);

    // Reset mid-frame after 5 beats
    clear_log();
    pulse_start(32'd1, 32'd1);
    k = 0;
    while (beats.size() < 5 && k < 40) begin tick(1); k++; end
    check("rst_beats_before", beats.size(), 5);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    tick(2);
    rst_n = 1'b1;
    tick(30);
    check("rst_beats_after", beats.size(), 5);
    check("rst_kp_count", kp_cyc.size(), 0);
    clear_log();
    pulse_start(32'd0, 32'd3);
    tick(35);
    check("rst_new_beat_count", beats.size(), 12);
    check_frame("rst_new", 0);

    // Start with hold high for two cycles
    clear_log();
    left_kp_in = 32'd2; right_kp_in = 32'd2;
    start = 1'b1; hold = 1'b1;
    tick(1);
    start = 1'b0;
    sc = cyc;
    check("sh_busy", 32'(busy), 32'h1);
    check("sh_rd_held", 32'(mem_rd_en), 32'h0);
    tick(1);
    hold = 1'b0;
    tick(35);
    check("sh_first_rd", rd_cyc[0] - sc, 1);
    check("sh_rd_count", rd_cyc.size(), 12);
    check("sh_beat_count", beats.size(), 12);
    check("sh_beat_span", beats[11].cyc - beats[0].cyc, 11);
    check_frame("sh", 0);
    check("sh_kp_count", kp_cyc.size(), 1);

    check("protocol_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
